sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO, the next generation of the UART byte FIFO, for use in UART TX/RX paths and any other single-clock buffering in the soft-core SoC. It adds:

- full-depth usage (all DEPTH entries usable);
- an occupancy count and programmable almost-full/almost-empty flags;
- sticky overflow/underflow error flags and a synchronous flush;
- a choice of registered-read or first-word-fall-through (FWFT) output.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_ram.sv | 36 +++
 rtl/sync_fifo_param.sv | 104 ++++++++++
 tb/tb_sync_fifo_param.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: address-width helper
// and output-mode selectors.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  function automatic int unsigned fifo_addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: one write port, one read port whose
// read timing (registered or combinational) is chosen by SYNC_READ.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned SYNC_READ = 0
) (
  input  logic                               clk,
  input  logic                               wr_en,
  input  logic [fifo_addr_width(DEPTH)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]                   wr_data,
  input  logic [fifo_addr_width(DEPTH)-1:0]  rd_addr,
  output logic [WIDTH-1:0]                   rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  if (SYNC_READ != 0) begin : g_sync
    always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
    end
  end else begin : g_async
    always_comb begin
      rd_data = mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky error flags, synchronous flush and registered or FWFT read output.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 1,
  parameter int unsigned FWFT      = FIFO_MODE_STD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned ADDRW = fifo_addr_width(DEPTH);
  localparam logic [ADDRW:0] AFULL_C  = (ADDRW + 1)'(AFULL_TH);
  localparam logic [ADDRW:0] AEMPTY_C = (ADDRW + 1)'(AEMPTY_TH);
  localparam logic [ADDRW:0] PTR_ONE  = {{ADDRW{1'b0}}, 1'b1};

  logic [ADDRW:0]   wr_ptr;
  logic [ADDRW:0]   rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  logic             ram_we;
  logic [WIDTH-1:0] ram_rd;

  // Status is a pure function of the registered pointers.
  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[ADDRW] != rd_ptr[ADDRW]) &&
                   (wr_ptr[ADDRW-1:0] == rd_ptr[ADDRW-1:0]);
    count        = wr_ptr - rd_ptr;
    almost_full  = (count >= AFULL_C);
    almost_empty = (count <= AEMPTY_C);
  end

  always_comb begin
    rd_acc = rd_en & ~empty;
    wr_acc = wr_en & (~full | rd_acc);
    ram_we = wr_acc & rst & ~flush;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (rd_en && !rd_acc) underflow <= 1'b1;
    end
  end

  fifo_ram #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .SYNC_READ (0)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr[ADDRW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[ADDRW-1:0]),
    .rd_data (ram_rd)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    always_comb begin
      rd_data  = ram_rd;
      rd_valid = ~empty;
    end
  end else begin : g_reg
    // rd_data only clears on reset; flush leaves the last popped word visible.
    always_ff @(posedge clk) begin
      if (!rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else if (flush) begin
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= ram_rd;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one FWFT instance share
// stimulus and are checked every cycle against a queue-based reference.
module tb_sync_fifo_param;

  localparam int unsigned W   = 8;
  localparam int unsigned D   = 16;
  localparam int unsigned AFT = 14;
  localparam int unsigned AET = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] wr_data = '0;

  logic [W-1:0] s_rd_data, f_rd_data;
  logic         s_rd_valid, f_rd_valid;
  logic         s_full, f_full, s_empty, f_empty;
  logic         s_af, f_af, s_ae, f_ae;
  logic [4:0]   s_count, f_count;
  logic         s_ovf, f_ovf, s_unf, f_unf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] q [$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;
  logic         m_rv  = 1'b0;
  logic [W-1:0] m_rd  = '0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AFULL_TH(AFT), .AEMPTY_TH(AET), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AFULL_TH(AFT), .AEMPTY_TH(AET), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the FIFO rules, applied at each rising edge.
  task automatic model;
    int unsigned n;
    logic racc, wacc;
    n = q.size();
    if (!rst || flush) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      if (!rst) m_rd = '0;
    end else begin
      racc = rd_en && (n != 0);
      wacc = wr_en && ((n != D) || racc);
      m_rv = racc;
      if (racc) m_rd = q.pop_front();
      if (wacc) q.push_back(wr_data);
      if (wr_en && !wacc) m_ovf = 1'b1;
      if (rd_en && !racc) m_unf = 1'b1;
    end
  endtask

  task automatic check_all;
    int unsigned n;
    n = q.size();
    chk("s_count",  32'(s_count), n);
    chk("s_full",   32'(s_full),  32'(n == D));
    chk("s_empty",  32'(s_empty), 32'(n == 0));
    chk("s_afull",  32'(s_af),    32'(n >= AFT));
    chk("s_aempty", 32'(s_ae),    32'(n <= AET));
    chk("s_ovf",    32'(s_ovf),   32'(m_ovf));
    chk("s_unf",    32'(s_unf),   32'(m_unf));
    chk("s_rvalid", 32'(s_rd_valid), 32'(m_rv));
    chk("s_rdata",  32'(s_rd_data),  32'(m_rd));
    chk("f_count",  32'(f_count), n);
    chk("f_full",   32'(f_full),  32'(n == D));
    chk("f_empty",  32'(f_empty), 32'(n == 0));
    chk("f_ovf",    32'(f_ovf),   32'(m_ovf));
    chk("f_unf",    32'(f_unf),   32'(m_unf));
    chk("f_rvalid", 32'(f_rd_valid), 32'(n != 0));
    if (n != 0) chk("f_rdata", 32'(f_rd_data), 32'(q[0]));
  endtask

  task automatic drive(input logic w, input logic r, input logic [W-1:0] d, input logic f);
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    flush   = f;
    @(posedge clk);
    model();
    #1;
    check_all();
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    rst = 1'b1;
    drive(0, 0, 8'h00, 0);

    // Fill to DEPTH, reject one more, drain in order
    for (int i = 1; i <= 16; i++) drive(1, 0, 8'(i), 0);
    drive(1, 0, 8'h11, 0);
    for (int i = 0; i < 16; i++) drive(0, 1, 8'h00, 0);
    drive(0, 0, 8'h00, 0);

    // Underflow on empty, cleared by flush
    drive(0, 0, 8'h00, 1);
    drive(0, 1, 8'h00, 0);
    drive(1, 1, 8'h42, 0);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 0);

    // Simultaneous read/write while full
    for (int i = 1; i <= 16; i++) drive(1, 0, 8'(i), 0);
    for (int i = 0; i < 5; i++) drive(1, 1, 8'(8'hA0 + i), 0);
    for (int i = 0; i < 17; i++) drive(0, 1, 8'h00, 0);
    drive(0, 0, 8'h00, 1);

    // FWFT visibility without rd_en, then pop
    drive(1, 0, 8'h5A, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'h00, 0);
    drive(0, 0, 8'h00, 0);

    // Flush with concurrent write, then fresh word lands first
    for (int i = 0; i < 3; i++) drive(1, 0, 8'(8'h30 + i), 0);
    drive(1, 0, 8'h99, 1);
    drive(0, 0, 8'h00, 0);
    drive(1, 0, 8'h77, 0);
    drive(0, 1, 8'h00, 0);
    drive(0, 0, 8'h00, 0);

    // Randomised traffic with phases biased toward filling or draining
    for (int i = 0; i < 600; i++) begin
      int unsigned bias;
      int unsigned r;
      bias = ((i / 60) % 2 == 0) ? 75 : 25;
      r = $urandom_range(0, 199);
      if (r < 2) begin
        rst = 1'b0;
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 0);
        rst = 1'b1;
      end else begin
        drive(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) >= bias - 10),
              8'($urandom), (r < 5));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
